// File: rtl/led_panel_uart_tx.sv
// led_panel_uart_tx: FIFO-buffered UART transmitter (8N1, LSB first) driving the LED panel uart_data line.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit after the data bits (8E1 framing).
module led_panel_uart_tx #(
    parameter int CLOCK_RATE = 1000,
    parameter int BAUD_RATE  = 100,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CPB = CLOCK_RATE / BAUD_RATE;
    localparam int TW  = $clog2(CPB);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(CPB - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    state_t          state_r;
    logic [TW-1:0]   timer_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      data_r;
    logic            tx_out_r;
`ifdef UART_TX_PARITY_EN
    logic            parity_r;
`endif

    logic [7:0]      mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [LW-1:0]   level_r;
    logic            tx_ready_r;
    logic            busy_r;

    logic            bit_end_s;
    logic            fifo_empty_s;
    logic            push_s;
    logic            pop_s;
    logic            idle_next_s;
    logic [LW-1:0]   level_next_s;
    logic [7:0]      head_s;

    // Handshake, pop decision and next FIFO occupancy shared by the FIFO and sequencer.
    always_comb begin
        bit_end_s    = (timer_r == TIMER_LAST);
        fifo_empty_s = (level_r == {LW{1'b0}});
        push_s       = tx_valid && tx_ready_r;
        head_s       = mem_r[rd_ptr_r];
        pop_s        = 1'b0;
        idle_next_s  = 1'b0;
        // A byte leaves the FIFO when the line is idle or exactly as a stop bit finishes.
        if (state_r == ST_IDLE) begin
            pop_s       = !fifo_empty_s;
            idle_next_s = fifo_empty_s;
        end else if ((state_r == ST_STOP) && bit_end_s) begin
            pop_s       = !fifo_empty_s;
            idle_next_s = fifo_empty_s;
        end else begin
            pop_s       = 1'b0;
            idle_next_s = 1'b0;
        end
        level_next_s = level_r + LW'(push_s) - LW'(pop_s);
    end

    // Byte FIFO with registered ready, busy and occupancy derived from next-cycle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= {LW{1'b0}};
            tx_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= tx_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r    <= level_next_s;
            tx_ready_r <= (level_next_s != LEVEL_FULL);
            busy_r     <= (!idle_next_s) || (level_next_s != {LW{1'b0}});
        end
    end

    // Frame sequencer: start, eight data bits LSB first, optional parity, stop; each bit lasts CPB clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            timer_r   <= {TW{1'b0}};
            bit_idx_r <= 3'd0;
            data_r    <= 8'h00;
            tx_out_r  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    timer_r   <= {TW{1'b0}};
                    bit_idx_r <= 3'd0;
                    if (pop_s) begin
                        data_r   <= head_s;
`ifdef UART_TX_PARITY_EN
                        parity_r <= even_parity(head_s);
`endif
                        tx_out_r <= 1'b0;
                        state_r  <= ST_START;
                    end else begin
                        tx_out_r <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        timer_r   <= {TW{1'b0}};
                        tx_out_r  <= data_r[0];
                        data_r    <= {1'b0, data_r[7:1]};
                        bit_idx_r <= 3'd0;
                        state_r   <= ST_DATA;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        timer_r <= {TW{1'b0}};
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_out_r <= parity_r;
                            state_r  <= ST_PARITY;
`else
                            tx_out_r <= 1'b1;
                            state_r  <= ST_STOP;
`endif
                        end else begin
                            tx_out_r  <= data_r[0];
                            data_r    <= {1'b0, data_r[7:1]};
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end_s) begin
                        timer_r  <= {TW{1'b0}};
                        tx_out_r <= 1'b1;
                        state_r  <= ST_STOP;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end_s) begin
                        timer_r   <= {TW{1'b0}};
                        bit_idx_r <= 3'd0;
                        // Queued byte starts immediately so consecutive frames have no idle gap.
                        if (pop_s) begin
                            data_r   <= head_s;
`ifdef UART_TX_PARITY_EN
                            parity_r <= even_parity(head_s);
`endif
                            tx_out_r <= 1'b0;
                            state_r  <= ST_START;
                        end else begin
                            tx_out_r <= 1'b1;
                            state_r  <= ST_IDLE;
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    timer_r   <= {TW{1'b0}};
                    bit_idx_r <= 3'd0;
                    tx_out_r  <= 1'b1;
                end
            endcase
        end
    end

    assign tx_out     = tx_out_r;
    assign tx_ready   = tx_ready_r;
    assign busy       = busy_r;
    assign fifo_level = level_r;

endmodule

// File: tb/tb_led_panel_uart_tx.sv
// Bench for led_panel_uart_tx: frame-level reference model checked every cycle, plus directed literal checks.
module tb_led_panel_uart_tx;

    localparam int CPB   = 10;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FLEN = NBITS * CPB;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_out;
    logic       busy;
    logic [2:0] fifo_level;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    led_panel_uart_tx #(.CLOCK_RATE(1000), .BAUD_RATE(100), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a queue of accepted bytes and the position inside the current frame.
    logic [7:0]  m_q[$];
    bit          m_active = 1'b0;
    int          m_pos    = 0;
    logic [10:0] m_frame  = 11'h7FF;
    bit          m_acc;
    logic [7:0]  m_b;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_active = 1'b0;
                m_pos    = 0;
            end else begin
                m_acc = tx_valid && (m_q.size() < DEPTH);
                if (m_active && (m_pos < FLEN - 1)) begin
                    m_pos++;
                end else if (m_q.size() > 0) begin
                    m_b = m_q.pop_front();
`ifdef UART_TX_PARITY_EN
                    m_frame = {1'b1, ^m_b, m_b, 1'b0};
`else
                    m_frame = {2'b11, m_b, 1'b0};
`endif
                    m_active = 1'b1;
                    m_pos    = 0;
                end else begin
                    m_active = 1'b0;
                end
                if (m_acc) m_q.push_back(tx_data);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("tx_out", 32'(tx_out), 32'(m_active ? m_frame[4'(m_pos / CPB)] : 1'b1));
            check("tx_ready", 32'(tx_ready), 32'(m_q.size() != DEPTH));
            check("busy", 32'(busy), 32'(m_active || (m_q.size() != 0)));
            check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        end
    end

    // Line receiver: decodes frames from tx_out at bit centres.
    logic [7:0] rx_q[$];
    int         start_q[$];
    bit         par_q[$];
    logic [7:0] rx_d;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (tx_out === 1'b0)) begin
                start_q.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    rx_d[i] = tx_out;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                par_q.push_back(tx_out);
`endif
                repeat (CPB) @(negedge clk);
                check("rx_stop_bit", 32'(tx_out), 32'd1);
                rx_q.push_back(rx_d);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b, output int waited);
        tx_valid = 1'b1;
        tx_data  = b;
        waited   = 0;
        while ((tx_ready !== 1'b1) && (waited < 4 * FLEN)) begin
            tx_data = ~b;
            @(negedge clk);
            waited++;
        end
        if (waited >= 4 * FLEN) check("send_timeout", 32'(waited), 32'd0);
        tx_data = b;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int max);
        int k = 0;
        while ((rx_q.size() < n) && (k < max)) begin
            @(negedge clk);
            k++;
        end
        check("rx_frame_count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while ((busy !== 1'b0) && (k < max)) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    int         w;
    logic [9:0] samp;
    logic [7:0] exp4 [6] = '{8'h11, 8'h81, 8'h42, 8'h24, 8'h18, 8'hE7};

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("rst_tx_out", 32'(tx_out), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);

        // Single 0xA5 frame with bit-centre samples.
        rx_q.delete(); start_q.delete();
        send(8'hA5, w);
        check("a5_before_fall", 32'(tx_out), 32'd1);
        check("a5_level_after_accept", 32'(fifo_level), 32'd1);
        @(negedge clk);
        check("a5_fall", 32'(tx_out), 32'd0);
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            samp[k] = tx_out;
            if (k < 9) repeat (CPB) @(negedge clk);
        end
`ifdef UART_TX_PARITY_EN
        check("a5_samples", 32'(samp), 32'h14A);
`else
        check("a5_samples", 32'(samp), 32'h34A);
`endif
        repeat (FLEN - 1 - (9 * CPB + CPB / 2)) @(negedge clk);
        check("a5_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        check("a5_busy_end", 32'(busy), 32'd0);
        check("a5_decoded", 32'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 32'hA5);

        // Three back-to-back frames.
        repeat (5) @(negedge clk);
        rx_q.delete(); start_q.delete();
        send(8'h00, w);
        send(8'hFF, w);
        send(8'h3C, w);
        wait_rx(3, 4 * FLEN);
        if (rx_q.size() == 3) begin
            check("b2b_byte0", 32'(rx_q[0]), 32'h00);
            check("b2b_byte1", 32'(rx_q[1]), 32'hFF);
            check("b2b_byte2", 32'(rx_q[2]), 32'h3C);
            check("b2b_gap01", 32'(start_q[1] - start_q[0]), 32'(FLEN));
            check("b2b_gap12", 32'(start_q[2] - start_q[1]), 32'(FLEN));
        end
        wait_idle(2 * FLEN);

        // Fill the FIFO while a frame is on the line; the fifth queued byte must wait for a pop.
        repeat (5) @(negedge clk);
        rx_q.delete(); start_q.delete();
        send(8'h11, w);
        repeat (3) @(negedge clk);
        send(8'h81, w);
        send(8'h42, w);
        send(8'h24, w);
        send(8'h18, w);
        check("full_ready", 32'(tx_ready), 32'd0);
        check("full_level", 32'(fifo_level), 32'd4);
        send(8'hE7, w);
        check("fifth_waited", 32'(w > CPB), 32'd1);
        wait_rx(6, 8 * FLEN);
        if (rx_q.size() == 6) begin
            for (int i = 0; i < 6; i++) check("fill_order", 32'(rx_q[i]), 32'(exp4[i]));
        end
        wait_idle(2 * FLEN);

        // Reset 35 cycles into a frame with another byte queued.
        repeat (5) @(negedge clk);
        send(8'h5A, w);
        send(8'hC3, w);
        repeat (35) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx_out", 32'(tx_out), 32'd1);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(tx_ready), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (100) @(negedge clk);
        rx_q.delete(); start_q.delete();
        repeat (200) @(negedge clk);
        check("no_frames_after_reset", 32'(start_q.size()), 32'd0);
        check("post_reset_line", 32'(tx_out), 32'd1);

`ifdef UART_TX_PARITY_EN
        rx_q.delete(); start_q.delete(); par_q.delete();
        send(8'h07, w);
        send(8'h03, w);
        wait_rx(2, 4 * FLEN);
        if (par_q.size() == 2) begin
            check("parity_07", 32'(par_q[0]), 32'd1);
            check("parity_03", 32'(par_q[1]), 32'd0);
            check("parity_frame_len", 32'(start_q[1] - start_q[0]), 32'd110);
        end
        wait_idle(2 * FLEN);
`endif

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
